// File: rtl/lane_unpacker_pkg.sv
// Shared types for the lane unpacker: lane/word typedefs, FSM states and an
// index-width helper. Used by lane_unpacker and its interface.
// Optional feature macro (consumed by lane_unpacker): LANE_UNPACKER_SKIP_FILL_EN.
package lane_pkg;

  localparam int NLANES_DEF = 4;
  localparam int LANE_W_DEF = 32;

  // Width of a lane position index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(NLANES_DEF);

  typedef logic [LANE_W_DEF-1:0] lane_t;

  typedef struct packed {
    lane_t [NLANES_DEF-1:0] lanes;
  } word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/lane_unpacker_if.sv
// Wide-in / lane-serial-out stream bundle for lane_unpacker.
// master = producer+consumer side, slave = the unpacker itself.
interface lane_unpacker_if #(
  parameter int NLANES = 4,
  parameter int LANE_W = 32
);
  import lane_pkg::*;

  localparam int IW = idx_w(NLANES);

  logic                     in_valid;
  logic                     in_ready;
  logic [NLANES*LANE_W-1:0] in_word;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANE_W-1:0]        out_data;
  logic [IW-1:0]            out_idx;
  logic                     out_last;
  logic                     all_fill;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, all_fill
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, all_fill
  );

endinterface

// File: rtl/lane_unpacker_next_sel.sv
// Next-set-bit finder over a lane keep mask (bit p = pattern position p).
// Returns the lowest set position strictly after idx_i, or the lowest set
// position overall when from_start_i is high. found_o is low if none exists.
module lane_next_sel #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] idx_i,
  input  logic          from_start_i,
  output logic [IW-1:0] next_o,
  output logic          found_o
);

  // Scan downward so the lowest qualifying position is the one that sticks.
  always_comb begin
    next_o  = {IW{1'b0}};
    found_o = 1'b0;
    for (int p = N - 1; p >= 0; p--) begin
      if (mask_i[p] && (from_start_i || (p > int'(idx_i)))) begin
        next_o  = IW'(p);
        found_o = 1'b1;
      end else begin
        next_o  = next_o;
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/lane_unpacker.sv
// lane_unpacker: accepts a wide word (NLANES x LANE_W) and replays it one lane
// per beat, MSB lane first, on a valid/ready stream. Back-to-back words are
// accepted on the last-lane handshake so the output never bubbles.
// Optional macro LANE_UNPACKER_SKIP_FILL_EN: lanes equal to FILL_VAL are
// skipped; an all-fill word emits nothing and pulses all_fill instead.
module lane_unpacker
  import lane_pkg::*;
#(
  parameter int                NLANES   = 4,
  parameter int                LANE_W   = 32,
  parameter logic [LANE_W-1:0] FILL_VAL = {LANE_W{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  lane_unpacker_if.slave bus
);

  localparam int IW = idx_w(NLANES);

  state_t                   state_q, state_d;
  logic [NLANES*LANE_W-1:0] word_q, word_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     all_fill_q, all_fill_d;

  logic out_valid_s;
  logic in_ready_s;
  logic accept_s;
  logic fire_s;
  logic last_s;
  logic has_lanes_s;
  logic [IW-1:0] first_idx_s;
  logic [IW-1:0] step_idx_s;

`ifdef LANE_UNPACKER_SKIP_FILL_EN
  logic [NLANES-1:0] mask_q, mask_d;
  logic [NLANES-1:0] new_mask_s;
  logic [NLANES-1:0] sel_mask_s;
  logic [IW-1:0]     next_idx_s;
  logic              next_found_s;

  // Keep mask of the incoming word, indexed by pattern position (0 = MSB lane).
  always_comb begin
    new_mask_s = {NLANES{1'b0}};
    for (int p = 0; p < NLANES; p++) begin
      new_mask_s[p] = (bus.in_word[(NLANES-1-p)*LANE_W +: LANE_W] != FILL_VAL);
    end
  end

  // Accept and advance never coincide, so one finder serves both.
  always_comb begin
    if (accept_s) begin
      sel_mask_s = new_mask_s;
    end else begin
      sel_mask_s = mask_q;
    end
  end

  lane_next_sel #(
    .N  (NLANES),
    .IW (IW)
  ) u_next_sel (
    .mask_i       (sel_mask_s),
    .idx_i        (idx_q),
    .from_start_i (accept_s),
    .next_o       (next_idx_s),
    .found_o      (next_found_s)
  );

  // Current lane is last when no kept position lies above it.
  always_comb begin
    last_s = 1'b1;
    for (int p = 0; p < NLANES; p++) begin
      if (mask_q[p] && (p > int'(idx_q))) begin
        last_s = 1'b0;
      end else begin
        last_s = last_s;
      end
    end
  end

  assign has_lanes_s = |new_mask_s;
  assign first_idx_s = next_idx_s;
  assign step_idx_s  = next_idx_s;
`else
  assign last_s      = (idx_q == IW'(NLANES - 1));
  assign has_lanes_s = 1'b1;
  assign first_idx_s = {IW{1'b0}};
  assign step_idx_s  = idx_q + {{(IW-1){1'b0}}, 1'b1};
`endif

  assign out_valid_s = (state_q == EMIT);
  assign fire_s      = out_valid_s && bus.out_ready;
  assign in_ready_s  = (state_q == IDLE) || (fire_s && last_s);
  assign accept_s    = bus.in_valid && in_ready_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load a word with lanes to emit, drop back after the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && has_lanes_s) begin
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (fire_s && last_s) begin
          if (accept_s && has_lanes_s) begin
            state_d = EMIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: reload on accept, step index on a non-last beat.
  always_comb begin
    word_d     = word_q;
    idx_d      = idx_q;
    all_fill_d = 1'b0;
`ifdef LANE_UNPACKER_SKIP_FILL_EN
    mask_d     = mask_q;
`endif
    if (accept_s) begin
      word_d     = bus.in_word;
      idx_d      = first_idx_s;
      all_fill_d = !has_lanes_s;
`ifdef LANE_UNPACKER_SKIP_FILL_EN
      mask_d     = new_mask_s;
`endif
    end else if (fire_s && !last_s) begin
      idx_d = step_idx_s;
    end else begin
      idx_d = idx_q;
    end
  end

  // Datapath registers: held word, lane position, fill pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= {(NLANES*LANE_W){1'b0}};
      idx_q      <= {IW{1'b0}};
      all_fill_q <= 1'b0;
`ifdef LANE_UNPACKER_SKIP_FILL_EN
      mask_q     <= {NLANES{1'b0}};
`endif
    end else begin
      word_q     <= word_d;
      idx_q      <= idx_d;
      all_fill_q <= all_fill_d;
`ifdef LANE_UNPACKER_SKIP_FILL_EN
      mask_q     <= mask_d;
`endif
    end
  end

  // Outputs: decoded purely from registered state; position p maps to lane NLANES-1-p.
  always_comb begin
    bus.out_valid = out_valid_s;
    bus.in_ready  = in_ready_s;
    bus.out_idx   = idx_q;
    bus.out_last  = out_valid_s && last_s;
    bus.all_fill  = all_fill_q;
    bus.out_data  = {LANE_W{1'b0}};
    for (int k = 0; k < NLANES; k++) begin
      if (idx_q == IW'(NLANES - 1 - k)) begin
        bus.out_data = word_q[k*LANE_W +: LANE_W];
      end else begin
        bus.out_data = bus.out_data;
      end
    end
  end

endmodule

// File: doc/lane_unpacker.md
Name: lane_unpacker

Overview:
- Reverse of the packed-array assignment pattern: takes a wide packed word (NLANES lanes of LANE_W bits) and emits it one lane per beat on a valid/ready stream.
- Lanes are emitted MSB lane first, matching positional pattern order: for '{1,2,3} into 96 bits, 1 goes out first.
- Sits between a wide producer (config/struct registers) and a narrow lane-serial consumer.

Parameters:
- NLANES, 4, number of lanes in the input word (>=2).
- LANE_W, 32, width of one lane in bits.
- FILL_VAL, 0, lane value treated as "default fill" (used only by the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_word  input  NLANES*LANE_W  packed word; lane k occupies bits [k*LANE_W +: LANE_W]; lane NLANES-1 is the MSB lane.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current lane.
- out_data  output  LANE_W  current lane value.
- out_idx  output  $clog2(NLANES)  pattern position of the lane (0 = MSB lane).
- out_last  output  1  current lane is the final lane of the word.
- all_fill  output  1  one-cycle pulse; meaningful only with the optional feature.

Behaviour:
- Clocking: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state IDLE, out_valid 0, out_idx 0, out_last 0, all_fill 0, out_data 0, held word 0. in_ready is 1 in IDLE once rst_n deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: out_valid=1, out_data = held lane (NLANES-1-idx).
- IDLE -> EMIT on in_valid&&in_ready. Latch in_word, set idx=0. First lane is visible the next cycle (latency 1).
- EMIT, out_valid&&out_ready:
  - not last: idx+1.
  - last: go to IDLE, unless a new word is accepted in the same cycle.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This gives zero-bubble back-to-back words. A word accepted on the last-lane handshake reloads the word register and idx=0, and the state stays EMIT.
- Without out_ready, out_data, out_idx and out_last hold stable. out_valid never drops before the handshake.
- out_last = (idx == NLANES-1) in the base build.
- in_word is ignored when in_ready=0.
- Reset mid-word: the held word is discarded, out_valid drops asynchronously, and no partial continuation occurs.
- idx arithmetic is unsigned and never exceeds NLANES-1. There is no wrap for non-power-of-2 NLANES.

Optional Feature:
- Macro: LANE_UNPACKER_SKIP_FILL_EN.
- Enabled:
  - On accept, compute an NLANES-bit keep mask (lane != FILL_VAL).
  - EMIT visits only kept lanes, in MSB-first order. idx jumps to the next kept position; out_idx reports the original position.
  - out_last marks the last kept lane.
  - If the mask is all-zero, no lane is emitted: all_fill pulses one cycle after accept, state stays IDLE, and in_ready stays 1.
- Disabled: every lane is emitted, the mask logic is absent, and all_fill is tied 0.

Decomposition:
- Shared package lane_pkg:
  - typedef lane_t (logic [LANE_W-1:0]).
  - typedef packed struct word_t containing lane_t [NLANES-1:0] lanes.
  - localparam IDX_W.
  - enum state_t {IDLE, EMIT}.
- One sub-module, lane_next_sel: combinational next-set-bit finder over the keep mask starting after idx. It returns next index and a found flag, and is instantiated only under the macro.

Test Plan:
- NLANES=3, LANE_W=32, in_word={32'd1,32'd2,32'd3}, out_ready=1 -> out_data 1,2,3 on consecutive cycles; out_idx 0,1,2; out_last only with 3; first beat 1 cycle after accept.
- Same word, out_ready low for 4 cycles on lane idx 1 -> out_data=2 and out_idx=1 held stable; in_ready=0 throughout.
- Two words {1,2,3} and {4,5,6} with in_valid high continuously -> 6 beats with no gap; second word accepted on the out_last handshake of the first.
- rst_n pulsed low while emitting idx 1 of {7,8,9} -> out_valid=0 immediately; after release in_ready=1 and no 9 appears.
- SKIP_FILL_EN, NLANES=4, FILL_VAL=0, word {0,5,0,7} -> beats 5 (idx 1) and 7 (idx 3, out_last=1).
- SKIP_FILL_EN, word {0,0,0,0} -> no out_valid; all_fill pulses one cycle after accept; next word accepted the following cycle.
